// File: rtl/ntsc_pixel_packer.sv
// ntsc_pixel_packer
// Single-clock NTSC pixel packer feeding the ZBT write arbiter.
// It tracks the x/y position from the decoder's {field, vsync, hsync} bits.
// It packs PIX_PER_WORD accepted pixels MSB-first into one memory word, addressed by
// the word's first pixel. Completed words are queued in a small FIFO.
// The FIFO is drained with a wr_req/wr_ack handshake.
// Interlaced row addressing and 2:1 decimation are selectable once per frame.
// Words that complete while the FIFO is full are dropped and counted.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous reset, active-low
//   fvh        {field, vsync, hsync}, already synchronised to clk
//   pix_valid  one-cycle strobe qualifying pix_data
//   pix_data   pixel value
//   interlace  insert field bit into row address (latched during vsync)
//   decimate   keep even pixels of even lines only (latched during vsync)
//   wr_addr    head-of-FIFO address (0 when empty)
//   wr_data    head-of-FIFO data (0 when empty)
//   wr_req     FIFO non-empty
//   wr_ack     arbiter takes the head entry this cycle
//   overflow   sticky, a completed word was dropped
//   drop_count dropped-word count, saturating
module ntsc_pixel_packer #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4,
  parameter int DATA_W       = 36,
  parameter int ADDR_W       = 19,
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 9,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        fvh,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              interlace,
  input  logic              decimate,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int LOG2_PPW  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 0;
  localparam int LANE_W    = (PIX_PER_WORD > 1) ? LOG2_PPW : 1;
  localparam int WCOL_BITS = X_BITS - LOG2_PPW;
  localparam int ROW_W     = Y_BITS + 1;
  // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [LANE_W-1:0] lane;
  logic              field_q, il_mode, dec_mode, hsync_q;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;

  logic              active, accept, last_lane, push;
  logic [X_BITS-1:0] xs;
  logic [Y_BITS-1:0] ys;
  logic [WCOL_BITS-1:0] wcol;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] lane0_addr, push_addr;
  logic [DATA_W-1:0] lane_bits, next_word;

  // A pixel at x = all-ones is treated as off-screen and ignored entirely
  always_comb begin
    active     = pix_valid && (fvh[1:0] == 2'b00) && (x != '1);
    accept     = active && (!dec_mode || (!x[0] && !y[0]));
    xs         = dec_mode ? (x >> 1) : x;
    ys         = dec_mode ? (y >> 1) : y;
    wcol       = WCOL_BITS'(xs >> LOG2_PPW);
    row        = il_mode ? {ys, field_q} : {1'b0, ys};
    lane0_addr = (ADDR_W'(row) << WCOL_BITS) | ADDR_W'(wcol);
    push_addr  = (lane == '0) ? lane0_addr : addr_q;
    lane_bits  = DATA_W'(pix_data) << (PIX_W * (PIX_PER_WORD - 1 - int'(lane)));
    next_word  = ((lane == '0) ? '0 : word_q) | lane_bits;
    last_lane  = (lane == LANE_W'(PIX_PER_WORD - 1));
    push       = accept && last_lane;
  end

  // Raster tracking and word assembly.
  // The completing pixel goes straight into the FIFO, so the word and address
  // registers only hold the partial word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      lane     <= '0;
      field_q  <= 1'b0;
      il_mode  <= 1'b0;
      dec_mode <= 1'b0;
      hsync_q  <= 1'b0;
      word_q   <= '0;
      addr_q   <= '0;
    end else begin
      hsync_q <= fvh[0];
      if (fvh[1]) begin
        il_mode  <= interlace;
        dec_mode <= decimate;
        field_q  <= fvh[2];
        y        <= '0;
      end else if (fvh[0] && !hsync_q && (y != '1)) begin
        y <= y + Y_BITS'(1);
      end
      if (fvh[0]) begin
        x    <= '0;
        lane <= '0;
      end else if (active) begin
        x <= x + X_BITS'(1);
        if (accept) begin
          word_q <= next_word;
          if (lane == '0) addr_q <= lane0_addr;
          lane <= last_lane ? '0 : lane + LANE_W'(1);
        end
      end
    end
  end

  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, pop, do_push, drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  always_comb begin
    full    = (count == CNT_W'(FIFO_DEPTH));
    pop     = wr_req && wr_ack;
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
  end

  // Storage needs no reset; the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= next_word;
    end
  end

  // FIFO bookkeeping and drop accounting
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !pop)      count <= count + CNT_W'(1);
      else if (!do_push && pop) count <= count - CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // The head outputs read 0 when the FIFO is empty
  assign wr_req  = (count != '0);
  assign wr_addr = wr_req ? mem_addr[rd_ptr] : '0;
  assign wr_data = wr_req ? mem_data[rd_ptr] : '0;

endmodule
